// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the future transmitter.
package uart_pkg;

   // Default bit period in system clocks (10 ns clock, 1560 ns bit).
   localparam int DEF_CLKS_PER_BIT = 156;

   // Frame shape: 8N1 -- one start bit, eight data bits, one stop bit.
   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   // Receiver FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   // Bits needed to hold a down-counter value in 0..n-1 (at least 1).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO. A push into a full
// FIFO is accepted when a pop happens in the same cycle; a pop while empty
// is ignored. Read data is forced to zero while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic             w_pop_ok;
   logic             w_push_ok;
   logic [AW:0]      w_count_nxt;

   assign o_empty   = (r_count == {(AW+1){1'b0}});
   assign o_full    = (r_count == COUNT_FULL);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   // Next occupancy from the accepted push/pop combination.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop_ok) begin
         w_count_nxt = r_count + (AW+1)'(1);
      end else if (w_pop_ok && !w_push_ok) begin
         w_count_nxt = r_count - (AW+1)'(1);
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Head of queue, zero while nothing is stored.
   always_comb begin
      if (o_empty) begin
         o_rdata = {WIDTH{1'b0}};
      end else begin
         o_rdata = r_mem[r_rd_ptr];
      end
   end

   // Pointer, occupancy and storage update; pointers wrap naturally.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else begin
         r_count <= w_count_nxt;
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small byte FIFO, with sticky
// frame-error and overrun flags. The serial line is synchronised by two flops
// and every FSM decision uses only the synchronised value.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       rxd,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       err_clr,
   output logic       rx_busy
);

   localparam int CNT_W = cnt_width(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_rxd_prev;
   rx_state_t            r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_frame_err;
   logic                 r_overrun;

   logic                 w_rxd;
   logic                 w_tick;
   rx_state_t            w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_push;
   logic                 w_frame_set;
   logic                 w_ovr_set;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;

   assign w_rxd  = r_sync2;
   assign w_tick = (r_cnt == {CNT_W{1'b0}});
   assign w_pop  = rd_valid & rd_ready;

   // Two-flop synchroniser plus previous-value flop for falling-edge detect.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_sync1    <= rxd;
         r_sync2    <= r_sync1;
         r_rxd_prev <= r_sync2;
      end
   end

   // FSM next state, bit timer, data shift and push/error decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_frame_set = 1'b0;
      w_ovr_set   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Only a high-to-low transition starts a frame, so a held-low
            // line cannot retrigger after its single framing error.
            if (r_rxd_prev && !w_rxd) begin
               w_state_nxt = ST_START;
               w_cnt_nxt   = CNT_HALF;
            end else begin
               w_cnt_nxt   = {CNT_W{1'b0}};
            end
         end
         ST_START: begin
            if (!w_tick) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (w_rxd) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = ST_DATA;
               w_cnt_nxt   = CNT_FULL;
               w_idx_nxt   = {IDX_W{1'b0}};
            end
         end
         ST_DATA: begin
            if (!w_tick) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_shift_nxt[r_bit_idx] = w_rxd;
               w_cnt_nxt              = CNT_FULL;
               if (r_bit_idx == IDX_LAST) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_idx_nxt = r_bit_idx + IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (!w_tick) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = {CNT_W{1'b0}};
               // A same-cycle pop frees a slot, so a full FIFO still accepts.
               if (!w_rxd) begin
                  w_frame_set = 1'b1;
               end else if (!w_full || w_pop) begin
                  w_push = 1'b1;
               end else begin
                  w_ovr_set = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM state, timer, bit index and shift register.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CNT_W{1'b0}};
         r_bit_idx <= {IDX_W{1'b0}};
         r_shift   <= {DATA_BITS{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_idx_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_frame_set) begin
            r_frame_err <= 1'b1;
         end else if (err_clr) begin
            r_frame_err <= 1'b0;
         end
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (err_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetb  (resetb),
      .i_push  (w_push),
      .i_wdata (w_shift_nxt),
      .i_pop   (w_pop),
      .o_rdata (rd_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign rd_valid  = ~w_empty;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors, corner sequences and a randomized run
// checked against a byte-queue model of the receiver.
module tb_uart_rx_fifo;

   localparam int BIT   = 156;
   localparam int DEPTH = 4;
   // Inputs change 2 time units after a rising edge. Counting edges from
   // the start-bit drive: two synchroniser edges, one detect edge, a
   // half-bit-minus-one count plus the terminal edge in START, then
   // 8 data bits and the stop bit of BIT edges each.
   localparam int STOP_EDGE = 3 + (BIT / 2 - 1) + 1 + 8 * BIT + BIT;

   logic       clk = 1'b0;
   logic       resetb;
   logic       rxd;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       frame_err;
   logic       overrun;
   logic       err_clr;
   logic       rx_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_fall = -1000;
   logic prev_busy = 1'b0;
   logic [7:0] got_q[$];
   int lat_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_n;
      logic       exp_ferr;
      logic       clr;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk       (clk),
      .resetb    (resetb),
      .rxd       (rxd),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .rx_busy   (rx_busy)
   );

   // Records every accepted byte and its distance from the end of the frame.
   always @(negedge clk) begin
      cyc       <= cyc + 1;
      prev_busy <= rx_busy;
      if (prev_busy && !rx_busy) last_fall <= cyc;
      if (resetb && rd_valid && rd_ready) begin
         got_q.push_back(rd_data);
         lat_q.push_back((prev_busy && !rx_busy) ? 0 : cyc - last_fall);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(BIT);
      end
      rxd = stop;
      tick(BIT);
      rxd = 1'b1;
      tick(8);
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] mq[$];
      logic [7:0] exp_q[$];
      logic mf;
      logic mo;
      logic [7:0] b;
      logic stop;
      int npop;

      vecs[0] = '{8'h41, 1'b1, 1, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1, 1'b0, 1'b0};
      vecs[3] = '{8'h55, 1'b0, 0, 1'b1, 1'b1};

      // Reset state
      resetb = 1'b0; rxd = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
      tick(3);
      chk("rst rd_valid",  32'(rd_valid),  32'd0);
      chk("rst rd_data",   32'(rd_data),   32'd0);
      chk("rst frame_err", 32'(frame_err), 32'd0);
      chk("rst overrun",   32'(overrun),   32'd0);
      chk("rst rx_busy",   32'(rx_busy),   32'd0);
      resetb = 1'b1;
      tick(5);

      // Table-driven frames with the consumer always ready
      rd_ready = 1'b1;
      foreach (vecs[k]) begin
         got_q.delete();
         lat_q.delete();
         send_frame(vecs[k].data, vecs[k].stop);
         chk($sformatf("v%0d count", k), 32'(got_q.size()), 32'(vecs[k].exp_n));
         if (got_q.size() > 0) begin
            chk($sformatf("v%0d data", k), 32'(got_q[0]), 32'(vecs[k].data));
            chk($sformatf("v%0d latency", k), 32'(lat_q[0] <= 1), 32'd1);
         end
         chk($sformatf("v%0d frame_err", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
         chk($sformatf("v%0d overrun", k), 32'(overrun), 32'd0);
         chk($sformatf("v%0d rd_valid", k), 32'(rd_valid), 32'd0);
         if (vecs[k].clr) begin
            pulse_clr();
            chk($sformatf("v%0d cleared", k), 32'(frame_err), 32'd0);
         end
      end

      // err_clr in the same cycle as a framing error: set wins
      fork
         send_frame(8'h3C, 1'b0);
         begin
            tick(STOP_EDGE - 1);
            err_clr = 1'b1;
            chk("setwin busy before", 32'(rx_busy), 32'd1);
            tick(1);
            err_clr = 1'b0;
            chk("setwin busy after", 32'(rx_busy), 32'd0);
            chk("setwin frame_err", 32'(frame_err), 32'd1);
         end
      join
      pulse_clr();
      chk("setwin cleared", 32'(frame_err), 32'd0);

      // Short low glitch: back to idle, nothing received
      got_q.delete();
      rxd = 1'b0;
      tick(40);
      chk("glitch busy", 32'(rx_busy), 32'd1);
      rxd = 1'b1;
      tick(150);
      chk("glitch idle", 32'(rx_busy), 32'd0);
      chk("glitch bytes", 32'(got_q.size()), 32'd0);
      chk("glitch flags", 32'({frame_err, overrun}), 32'd0);

      // Break: a held-low line gives exactly one framing error
      rxd = 1'b0;
      tick(1600);
      chk("break frame_err", 32'(frame_err), 32'd1);
      chk("break busy", 32'(rx_busy), 32'd0);
      pulse_clr();
      tick(1600);
      chk("break no retrigger", 32'(frame_err), 32'd0);
      chk("break still idle", 32'(rx_busy), 32'd0);
      rxd = 1'b1;
      tick(10);
      chk("break bytes", 32'(got_q.size()), 32'd0);

      // Overrun: five bytes into a four-entry FIFO with no reads
      rd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      chk("ovr overrun", 32'(overrun), 32'd1);
      chk("ovr frame_err", 32'(frame_err), 32'd0);
      chk("ovr head", 32'(rd_data), 32'h01);
      got_q.delete();
      repeat (DEPTH) pop_one();
      chk("ovr count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < got_q.size(); i++)
         chk($sformatf("ovr byte%0d", i), 32'(got_q[i]), 32'(i + 1));
      chk("ovr empty", 32'(rd_valid), 32'd0);

      // Full FIFO with a pop in the stop-sample cycle: push and pop both occur
      pulse_clr();
      chk("full pre overrun", 32'(overrun), 32'd0);
      for (int i = 0; i < DEPTH; i++) send_frame(8'(8'hA0 + i), 1'b1);
      chk("full valid", 32'(rd_valid), 32'd1);
      got_q.delete();
      fork
         send_frame(8'hA4, 1'b1);
         begin
            tick(STOP_EDGE - 1);
            rd_ready = 1'b1;
            chk("full busy before", 32'(rx_busy), 32'd1);
            tick(1);
            rd_ready = 1'b0;
            chk("full busy after", 32'(rx_busy), 32'd0);
            chk("full overrun", 32'(overrun), 32'd0);
         end
      join
      repeat (DEPTH) pop_one();
      chk("full count", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < got_q.size(); i++)
         chk($sformatf("full byte%0d", i), 32'(got_q[i]), 32'(8'hA0 + i));
      chk("full empty", 32'(rd_valid), 32'd0);
      chk("full overrun end", 32'(overrun), 32'd0);

      // Reset in the middle of data bit 3, then a clean byte
      rd_ready = 1'b1;
      b = 8'h99;
      rxd = 1'b0;
      tick(BIT);
      for (int i = 0; i < 3; i++) begin
         rxd = b[i];
         tick(BIT);
      end
      rxd = b[3];
      tick(BIT / 2);
      chk("mid busy", 32'(rx_busy), 32'd1);
      resetb = 1'b0;
      rxd = 1'b1;
      tick(2);
      chk("mid rst busy", 32'(rx_busy), 32'd0);
      chk("mid rst valid", 32'(rd_valid), 32'd0);
      resetb = 1'b1;
      tick(20);
      got_q.delete();
      send_frame(8'h41, 1'b1);
      chk("post rst count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("post rst byte", 32'(got_q[0]), 32'h41);
      chk("post rst flags", 32'({frame_err, overrun}), 32'd0);

      // Randomized frames against a byte-queue model
      rd_ready = 1'b0;
      mq.delete();
      mf = 1'b0;
      mo = 1'b0;
      for (int n = 0; n < 12; n++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         send_frame(b, stop);
         if (!stop) mf = 1'b1;
         else if (mq.size() < DEPTH) mq.push_back(b);
         else mo = 1'b1;
         chk($sformatf("rnd%0d frame_err", n), 32'(frame_err), 32'(mf));
         chk($sformatf("rnd%0d overrun", n), 32'(overrun), 32'(mo));
         chk($sformatf("rnd%0d valid", n), 32'(rd_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) chk($sformatf("rnd%0d head", n), 32'(rd_data), 32'(mq[0]));
         npop = $urandom_range(0, 2);
         got_q.delete();
         exp_q.delete();
         for (int j = 0; j < npop; j++) begin
            pop_one();
            if (mq.size() > 0) exp_q.push_back(mq.pop_front());
         end
         chk($sformatf("rnd%0d pops", n), 32'(got_q.size()), 32'(exp_q.size()));
         for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
            chk($sformatf("rnd%0d byte%0d", n, j), 32'(got_q[j]), 32'(exp_q[j]));
         if ($urandom_range(0, 3) == 0) begin
            pulse_clr();
            mf = 1'b0;
            mo = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
